// File: rtl/instr_seq.sv
// instr_seq: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT) driving ROM, register file and data memory.
// Optional execution cycle counter is built only when INSTR_SEQ_CYCLE_CNT_EN is defined.
module instr_seq (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [8:0]  Inst,
    input  logic        BranchTaken,
    input  logic [9:0]  BranchTarget,
    input  logic        NoWrite,
    input  logic        MemReady,
    output logic [9:0]  PC,
    output logic [8:0]  InstReg,
    output logic        RegWrEn,
    output logic        MemReq,
    output logic        MemWr,
    output logic        Done,
    output logic [15:0] CycleCount
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       branch_taken_q;
    logic [9:0] branch_target_q;
    logic       is_mem_op;
    logic       is_store;
    logic       start_accept;

    // Loads use opcode 011, stores 111; both require bit 8 and bit 0 clear.
    assign is_mem_op    = !InstReg[8] && !InstReg[0] &&
                          ((InstReg[7:5] == 3'b011) || (InstReg[7:5] == 3'b111));
    assign is_store     = is_mem_op && InstReg[7];
    assign start_accept = Start && ((state == IDLE) || (state == HALT));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs decode from the state register so a reset removes them without waiting for an edge.
    always_comb begin
        next_state = state;
        RegWrEn    = 1'b0;
        MemReq     = 1'b0;
        MemWr      = 1'b0;
        Done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state = DECODE;
            end
            DECODE: begin
                next_state = (InstReg == 9'h1FF) ? HALT : EXEC;
            end
            EXEC: begin
                next_state = is_mem_op ? MEM : WB;
            end
            MEM: begin
                MemReq = 1'b1;
                MemWr  = is_store;
                if (MemReady) begin
                    next_state = WB;
                end
            end
            WB: begin
                RegWrEn    = !NoWrite && !is_store;
                next_state = FETCH;
            end
            HALT: begin
                Done = 1'b1;
                if (Start) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PC              <= '0;
            InstReg         <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            if (start_accept) begin
                PC <= '0;
            end else if (state == WB) begin
                PC <= branch_taken_q ? branch_target_q : PC + 10'd1;
            end
            if (state == FETCH) begin
                InstReg <= Inst;
            end
            if (state == EXEC) begin
                branch_taken_q  <= BranchTaken;
                branch_target_q <= BranchTarget;
            end
        end
    end

`ifdef INSTR_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_count_q;
    logic        counting;

    assign counting = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                      (state == MEM) || (state == WB);

    // Counts only active execution cycles, saturating so long programs never wrap back to small values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycle_count_q <= '0;
        end else if (start_accept) begin
            cycle_count_q <= '0;
        end else if (counting && (cycle_count_q != 16'hFFFF)) begin
            cycle_count_q <= cycle_count_q + 16'd1;
        end
    end

    assign CycleCount = cycle_count_q;
`else
    assign CycleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: randomized scoreboard bench for instr_seq; a program-level reference model predicts
// register writes, memory requests and halts with their cycle timing relative to Start.
`timescale 1ns/1ps
module tb_instr_seq;

    localparam int EV_WR   = 0;
    localparam int EV_MEM  = 1;
    localparam int EV_HALT = 2;

    typedef struct {
        int          kind;
        int          rel_t;
        logic [9:0]  pc;
        logic [8:0]  inst;
        logic        wr;
        logic [15:0] count;
    } event_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [8:0]  Inst;
    logic        BranchTaken;
    logic [9:0]  BranchTarget;
    logic        NoWrite;
    logic        MemReady;
    logic [9:0]  PC;
    logic [8:0]  InstReg;
    logic        RegWrEn;
    logic        MemReq;
    logic        MemWr;
    logic        Done;
    logic [15:0] CycleCount;

    logic [8:0]  rom      [1024];
    logic        bt_mem   [1024];
    logic [9:0]  tgt_mem  [1024];
    logic        nw_mem   [1024];
    int          wait_mem [1024];

    event_t      exp_q[$];
    int          cyc;
    int          t0;
    int          errors;
    int          checks;
    int          req_cycles;
    logic        mem_req_prev;
    logic        done_prev;
    logic [9:0]  halt_pc;

    instr_seq dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Inst         (Inst),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .NoWrite      (NoWrite),
        .MemReady     (MemReady),
        .PC           (PC),
        .InstReg      (InstReg),
        .RegWrEn      (RegWrEn),
        .MemReq       (MemReq),
        .MemWr        (MemWr),
        .Done         (Done),
        .CycleCount   (CycleCount)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // The ROM and per-address ALU/decode answers behave like combinational lookups on PC.
    assign Inst         = rom[PC];
    assign BranchTaken  = bt_mem[PC];
    assign BranchTarget = tgt_mem[PC];
    assign NoWrite      = nw_mem[PC];

    // Memory responder: acknowledges after the per-address wait, random noise while no request is open.
    always @(negedge Clk) begin
        if (MemReq) begin
            MemReady   <= (req_cycles >= wait_mem[PC]);
            req_cycles <= req_cycles + 1;
        end else begin
            MemReady   <= 1'($urandom_range(0, 1));
            req_cycles <= 0;
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic checkOutput(input int kind);
        event_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: actual kind=%0d t=%0d pc=%h required no event", kind, cyc - t0, PC);
            return;
        end
        e = exp_q.pop_front();
        if ((e.kind != kind) || (e.rel_t != cyc - t0) || (e.pc !== PC) || (e.inst !== InstReg) ||
            ((kind == EV_MEM) && (MemWr !== e.wr)) || ((kind == EV_HALT) && (CycleCount !== e.count))) begin
            errors++;
            $display("[TB] FAIL event: actual kind=%0d t=%0d pc=%h inst=%h wr=%b cnt=%0d required kind=%0d t=%0d pc=%h inst=%h wr=%b cnt=%0d",
                     kind, cyc - t0, PC, InstReg, MemWr, CycleCount,
                     e.kind, e.rel_t, e.pc, e.inst, e.wr, e.count);
        end
    endtask

    // Monitor: every observable DUT action is matched against the next scoreboard entry.
    always @(negedge Clk) begin
        if (Reset) begin
            mem_req_prev <= 1'b0;
            done_prev    <= 1'b0;
        end else begin
            if (RegWrEn) checkOutput(EV_WR);
            if (MemReq && !mem_req_prev) checkOutput(EV_MEM);
            if (Done && !done_prev) checkOutput(EV_HALT);
            mem_req_prev <= MemReq;
            done_prev    <= Done;
        end
    end

    task automatic pushEvent(input int kind, input int rel_t, input logic [9:0] pc, input logic [8:0] inst,
                             input logic wr, input logic [15:0] count);
        event_t e;
        e.kind  = kind;
        e.rel_t = rel_t;
        e.pc    = pc;
        e.inst  = inst;
        e.wr    = wr;
        e.count = count;
        exp_q.push_back(e);
    endtask

    // Reference model: walks the program instruction by instruction using the documented latencies.
    task automatic modelProgram(input int max_instr, input bit cut_after_mem, output bit halts);
        logic [9:0]  pc;
        logic [8:0]  ins;
        logic [15:0] cnt;
        int          t;
        bit          mem_op;
        bit          store;
        pc    = '0;
        t     = 0;
        halts = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            ins = rom[pc];
            if (ins == 9'h1FF) begin
`ifdef INSTR_SEQ_CYCLE_CNT_EN
                cnt = (t + 2 > 65535) ? 16'hFFFF : 16'(t + 2);
`else
                cnt = 16'h0000;
`endif
                pushEvent(EV_HALT, t + 2, pc, ins, 1'b0, cnt);
                halts   = 1'b1;
                halt_pc = pc;
                return;
            end
            mem_op = !ins[8] && !ins[0] && ((ins[7:5] == 3'b011) || (ins[7:5] == 3'b111));
            store  = mem_op && ins[7];
            if (mem_op) begin
                pushEvent(EV_MEM, t + 3, pc, ins, store, 16'h0);
                if (cut_after_mem) return;
                t += 1 + wait_mem[pc];
            end
            if (!nw_mem[pc] && !store) pushEvent(EV_WR, t + 3, pc, ins, 1'b0, 16'h0);
            pc = bt_mem[pc] ? tgt_mem[pc] : pc + 10'd1;
            t += 4;
        end
    endtask

    task automatic fillProgram(input bit random_fill);
        for (int i = 0; i < 1024; i++) begin
            if (random_fill) begin
                case ($urandom_range(0, 5))
                    0:       rom[i] = 9'h1FF;
                    1:       rom[i] = {1'b0, 3'b011, 4'($urandom), 1'b0};
                    2:       rom[i] = {1'b0, 3'b111, 4'($urandom), 1'b0};
                    default: rom[i] = 9'($urandom);
                endcase
                bt_mem[i]   = ($urandom_range(0, 3) == 0);
                tgt_mem[i]  = ($urandom_range(0, 7) == 0) ? 10'h000 : 10'($urandom);
                nw_mem[i]   = ($urandom_range(0, 3) == 0);
                wait_mem[i] = $urandom_range(0, 3);
            end else begin
                rom[i]      = 9'h1FF;
                bt_mem[i]   = 1'b0;
                tgt_mem[i]  = 10'h000;
                nw_mem[i]   = 1'b0;
                wait_mem[i] = 0;
            end
        end
    endtask

    task automatic resetDut();
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        Start = 1'b0;
        #1;
        checkValue("reset_pc", 32'(PC), 32'h0);
        checkValue("reset_instreg", 32'(InstReg), 32'h0);
        checkValue("reset_regwren", 32'(RegWrEn), 32'h0);
        checkValue("reset_memreq", 32'(MemReq), 32'h0);
        checkValue("reset_memwr", 32'(MemWr), 32'h0);
        checkValue("reset_done", 32'(Done), 32'h0);
        checkValue("reset_cyclecount", 32'(CycleCount), 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        checkValue("idle_without_start", {20'h0, PC, Done, MemReq}, 32'h0);
    endtask

    // Runs one program from PC 0; runs that never halt are cut off by a reset after the last prediction.
    task automatic applyStimulus(input int max_instr, input bit cut_after_mem);
        bit halts;
        int budget;
        modelProgram(max_instr, cut_after_mem, halts);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        t0    = cyc;
        budget = 0;
        while ((exp_q.size() != 0) && (budget < 2000)) begin
            @(negedge Clk);
            #1;
            Start = (exp_q.size() != 0) && ($urandom_range(0, 7) == 0);
            budget++;
        end
        Start = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL event_timeout: actual %0d events pending required 0", exp_q.size());
            exp_q.delete();
            halts = 1'b0;
        end
        if (halts) begin
            repeat (2) @(negedge Clk);
            #1;
            checkValue("halt_hold", {21'h0, PC, Done}, {21'h0, halt_pc, 1'b1});
        end else begin
            resetDut();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b1;
        Start  = 1'b0;
        fillProgram(1'b0);
        resetDut();

        $display("[TB] immediate halt");
        applyStimulus(4, 1'b0);

        $display("[TB] single R-type then halt");
        fillProgram(1'b0);
        rom[0] = 9'h002;
        applyStimulus(4, 1'b0);

        $display("[TB] load with three wait cycles, then store");
        fillProgram(1'b0);
        rom[0]      = 9'b001100000;
        wait_mem[0] = 3;
        applyStimulus(4, 1'b0);
        fillProgram(1'b0);
        rom[0]      = 9'b011100000;
        wait_mem[0] = 1;
        applyStimulus(4, 1'b0);

        $display("[TB] branch to 3FF and wrap to 0");
        fillProgram(1'b0);
        for (int i = 0; i < 5; i++) rom[i] = 9'h002;
        rom[5]      = 9'h004;
        bt_mem[5]   = 1'b1;
        tgt_mem[5]  = 10'h3FF;
        rom[10'h3FF] = 9'h006;
        applyStimulus(8, 1'b0);

        $display("[TB] reset during memory wait");
        fillProgram(1'b0);
        rom[0]      = 9'b001100000;
        wait_mem[0] = 6;
        applyStimulus(2, 1'b1);

        $display("[TB] two instructions then halt");
        fillProgram(1'b0);
        rom[0] = 9'h002;
        rom[1] = 9'h004;
        applyStimulus(4, 1'b0);

        $display("[TB] random programs");
        for (int p = 0; p < 30; p++) begin
            fillProgram(1'b1);
            if ($urandom_range(0, 3) == 0) resetDut();
            applyStimulus($urandom_range(1, 12), 1'b0);
        end

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
